// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
// Scan states, ASCII classification and the segment lookup table.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    BLANK_R,
    SHOW_R,
    BLANK_L,
    SHOW_L
  } scan_st_e;

  typedef enum logic [1:0] {
    CH_HEX,
    CH_EOL,
    CH_BAD
  } ch_kind_e;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;

  // {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic ch_kind_e ch_kind(input logic [7:0] c);
    ch_kind_e k;
    k = CH_BAD;
    if (c >= ASC_0 && c <= ASC_0 + 8'd9)
      k = CH_HEX;
    else if (c >= ASC_UA && c <= ASC_UA + 8'd5)
      k = CH_HEX;
    else if (c >= ASC_LA && c <= ASC_LA + 8'd5)
      k = CH_HEX;
    else if (c == ASC_LF || c == ASC_CR)
      k = CH_EOL;
    return k;
  endfunction

  function automatic logic [3:0] ch_nib(input logic [7:0] c);
    logic [7:0] d;
    if (c <= ASC_0 + 8'd9)
      d = c - ASC_0;
    else if (c <= ASC_UA + 8'd5)
      d = c - ASC_UA + 8'd10;
    else
      d = c - ASC_LA + 8'd10;
    return d[3:0];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to seven-segment pattern encoder.
// Output is active-high {g,f,e,d,c,b,a}.
module hex_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TAB[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller with blanking between digits.
// Bytes arrive over valid/ready and commit only at digit blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_CYC = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       ck_rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [6:0] seg,
  output logic       digit,
  output logic [3:0] led
);

  localparam int MAXC = (REFRESH_CYC > BLANK_CYC) ? REFRESH_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  scan_st_e    r_state;
  scan_st_e    w_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_lim;
  logic        w_last;
  logic        w_show;
  logic        w_take;
  logic        w_commit;
  logic        r_pending;
  logic [7:0]  r_byte;
  logic [3:0]  r_buf_l;
  logic [3:0]  r_buf_r;
  logic [3:0]  w_sel;
  logic [6:0]  w_enc;

  assign w_show = (r_state == SHOW_R) || (r_state == SHOW_L);
  assign w_lim  = w_show ? CW'(REFRESH_CYC - 1) : CW'(BLANK_CYC - 1);
  assign w_last = (r_cnt == w_lim);
  assign w_take = rx_valid && rx_ready;
  // Leaving a SHOW state means entering a BLANK state: safe to swap digits.
  assign w_commit = w_last && w_show && r_pending;

  always_comb begin
    w_nxt = r_state;
    if (w_last) begin
      case (r_state)
        BLANK_R: w_nxt = SHOW_R;
        SHOW_R:  w_nxt = BLANK_L;
        BLANK_L: w_nxt = SHOW_L;
        default: w_nxt = BLANK_R;
      endcase
    end
  end

  assign w_sel = (w_nxt == SHOW_L) ? r_buf_l : r_buf_r;

  hex_to_seg u_enc (
    .i_nib (w_sel),
    .o_seg (w_enc)
  );

  always_ff @(posedge CLK100MHZ or negedge ck_rstn) begin
    if (!ck_rstn) begin
      r_state   <= BLANK_R;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_byte    <= '0;
      r_buf_l   <= '0;
      r_buf_r   <= '0;
      rx_ready  <= 1'b1;
      seg       <= '0;
      digit     <= 1'b0;
      led       <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      digit   <= (w_nxt == BLANK_L) || (w_nxt == SHOW_L);
      seg     <= (w_nxt == SHOW_R || w_nxt == SHOW_L) ? w_enc : '0;
      if (w_take) begin
        r_pending <= 1'b1;
        r_byte    <= rx_data;
        rx_ready  <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b0;
        rx_ready  <= 1'b1;
        case (ch_kind(r_byte))
          CH_HEX: begin
            r_buf_l  <= r_buf_r;
            r_buf_r  <= ch_nib(r_byte);
            led[2:0] <= led[2:0] + 3'd1;
            led[3]   <= 1'b0;
          end
          CH_BAD:  led[3] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 20-clock scan period.
// Tracks scan phase and digit buffer independently of the design.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [6:0] seg;
  logic       digit;
  logic [3:0] led;

  int n_vec;
  int n_bad;
  int k;
  logic [3:0] m_l;
  logic [3:0] m_r;
  logic [2:0] m_cnt;
  logic       m_err;

  seg_scan_ctrl #(
    .REFRESH_CYC (8),
    .BLANK_CYC   (2)
  ) dut (
    .CLK100MHZ (clk),
    .ck_rstn   (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .seg       (seg),
    .digit     (digit),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06;
      4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D;
      4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F;
      4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E;
      4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int phase();
    return k % 20;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic apply_model(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) begin
      m_l = m_r; m_r = 4'(b - 8'h30); m_cnt++; m_err = 1'b0;
    end else if (b >= 8'h41 && b <= 8'h46) begin
      m_l = m_r; m_r = 4'(b - 8'h37); m_cnt++; m_err = 1'b0;
    end else if (b >= 8'h61 && b <= 8'h66) begin
      m_l = m_r; m_r = 4'(b - 8'h57); m_cnt++; m_err = 1'b0;
    end else if (b != 8'h0A && b != 8'h0D) begin
      m_err = 1'b1;
    end
  endtask

  task automatic wait_commit(input string nm);
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_vec++;
    if (rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready timeout: rx_ready=%b required 1", nm, rx_ready);
    end
    n_vec++;
    if (phase() != 0 && phase() != 10) begin
      n_bad++;
      $display("FAIL %s commit phase: got %0d required 0 or 10", nm, phase());
    end
  endtask

  task automatic send(input logic [7:0] b, input string nm);
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_vec++;
    if (rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready drop: rx_ready=%b required 0", nm, rx_ready);
    end
    wait_commit(nm);
    apply_model(b);
  endtask

  task automatic scan(input string nm);
    logic [6:0] es;
    logic       ed;
    n_vec++;
    if (led !== {m_err, m_cnt}) begin
      n_bad++;
      $display("FAIL %s led: got %b required %b", nm, led, {m_err, m_cnt});
    end
    for (int i = 0; i < 20; i++) begin
      ed = (phase() >= 10);
      if (phase() >= 2 && phase() < 10)
        es = enc(m_r);
      else if (phase() >= 12)
        es = enc(m_l);
      else
        es = 7'h00;
      n_vec++;
      if (seg !== es || digit !== ed) begin
        n_bad++;
        $display("FAIL %s p%0d: seg=%h digit=%b required seg=%h digit=%b",
                 nm, phase(), seg, digit, es, ed);
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    m_l = 0; m_r = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (seg !== 7'h00 || digit !== 1'b0 || led !== 4'h0 || rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: seg=%h digit=%b led=%h rdy=%b required 00 0 0 1",
               seg, digit, led, rx_ready);
    end
    scan("idle0");
    scan("idle1");
  endtask

  task automatic test_single();
    send(8'h35, "five");
    scan("five");
  endtask

  task automatic test_two();
    send(8'h33, "three");
    send(8'h61, "lower_a");
    scan("three_a");
  endtask

  task automatic test_error();
    send(8'h47, "bad_G");
    scan("bad_G");
    send(8'h31, "one");
    scan("one");
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    rx_data  = 8'h37;
    rx_valid = 1'b1;
    step();
    rx_data = 8'h38;
    n_vec++;
    if (rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b hold: rx_ready=%b required 0", rx_ready);
    end
    wait_commit("b2b_first");
    apply_model(8'h37);
    step();
    rx_valid = 1'b0;
    n_vec++;
    if (rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b second take: rx_ready=%b required 0", rx_ready);
    end
    wait_commit("b2b_second");
    apply_model(8'h38);
    scan("b2b");
    send(8'h0D, "cr");
    scan("cr");
  endtask

  task automatic test_reset_pending();
    int n;
    n = 0;
    while (phase() != 12 && n < 40) begin
      step();
      n++;
    end
    rx_data  = 8'h39;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (seg !== 7'h00 || digit !== 1'b0 || led !== 4'h0 || rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset: seg=%h digit=%b led=%h rdy=%b required 00 0 0 1",
               seg, digit, led, rx_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    m_l = 0; m_r = 0; m_cnt = 0; m_err = 0;
    scan("post_rst0");
    scan("post_rst1");
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    k        = 0;
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_single();
    test_two();
    test_error();
    test_back_to_back();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
